// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Sequencer for an LSB-first bit-serial adder. Operands live in two external
// PISO registers and the sum is collected in an external SIPO register. This
// block drives their load/shift strobes and keeps the running carry. It also
// presents the serial sum bit and the final carry-out.
//
// Compile option: SERIAL_ADD_OVF_EN adds a registered two's-complement
// overflow output (ovf).
module serial_add_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic a_bit,
    input  logic b_bit,
    output logic load,
    output logic shift,
    output logic sum_bit,
    output logic busy,
    output logic done,
    output logic cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic ovf
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          carry_q, carry_d;
    logic          cout_q, cout_d;
    logic          load_q, load_d;
    logic          shift_q, shift_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          carry_nxt_s;
`ifdef SERIAL_ADD_OVF_EN
    logic          ovf_q, ovf_d;
`endif

    // Full-adder carry: majority of the three input bits.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    assign carry_nxt_s = maj3(a_bit, b_bit, carry_q);
    assign sum_bit     = a_bit ^ b_bit ^ carry_q;

    assign load  = load_q;
    assign shift = shift_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign cout  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign ovf   = ovf_q;
`endif

    // Next-state, datapath updates and the next values of the strobe outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = '0;
                carry_d = 1'b0;
                cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                ovf_d   = 1'b0;
`endif
            end
            SHIFT: begin
                carry_d = carry_nxt_s;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == LAST_BIT) begin
                    state_d = DONE;
                    cout_d  = carry_nxt_s;
`ifdef SERIAL_ADD_OVF_EN
                    // carry into the MSB is carry_q, carry out is carry_nxt_s
                    ovf_d   = carry_q ^ carry_nxt_s;
`endif
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are registered from the next state so they line up with it.
        load_d  = (state_d == LOAD);
        shift_d = (state_d == SHIFT);
        busy_d  = (state_d == LOAD) || (state_d == SHIFT);
        done_d  = (state_d == DONE);
    end

    // State, counter, carry and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            load_q  <= load_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl. It models the operand PISOs and the
// result SIPO around the DUT. Expected results come from plain integer
// addition and are queued at issue time. A negedge monitor checks each done.
module tb_serial_add_ctrl;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst;
    logic start;
    logic a_bit, b_bit;
    logic load, shift, sum_bit, busy, done, cout;
`ifdef SERIAL_ADD_OVF_EN
    logic ovf;
`endif

    logic [W-1:0] a_val, b_val;
    logic [W-1:0] piso_a, piso_b, sipo;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   load_cyc = 0;
    int   done_cyc = 0;
    int   shift_cnt = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a_bit   (a_bit),
        .b_bit   (b_bit),
        .load    (load),
        .shift   (shift),
        .sum_bit (sum_bit),
        .busy    (busy),
        .done    (done),
        .cout    (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Operand PISOs (LSB out first) and result SIPO (fills from the top).
    assign a_bit = piso_a[0];
    assign b_bit = piso_b[0];
    always @(posedge clk) begin
        if (load) begin
            piso_a <= a_val;
            piso_b <= b_val;
        end else if (shift) begin
            piso_a <= piso_a >> 1;
            piso_b <= piso_b >> 1;
        end
        if (shift) sipo <= {sum_bit, sipo[W-1:1]};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: plain W+1 bit addition.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t r;
        logic [W:0] full;
        full   = {1'b0, a} + {1'b0, b};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return r;
    endfunction

    // Monitor: strobe relations every cycle, full result check on each done.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            check("busy_vs_strobes", busy, load | shift);
            check("strobes_exclusive", (int'(load) + int'(shift) + int'(done)) <= 1, 1);
            if (load === 1'b1) shift_cnt = 0;
            if (shift === 1'b1) shift_cnt++;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", sipo, e.sum);
                    check("cout", cout, e.cout);
`ifdef SERIAL_ADD_OVF_EN
                    check("ovf", ovf, e.ovf);
`endif
                    check("shift_cycles", shift_cnt, W);
                    check("busy_in_done", busy, 0);
                end
            end
        end
    end

    // Raise start in the next cycle, queue the expectation, confirm load.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        a_val = a;
        b_val = b;
        start = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        load_cyc = cyc;
        check("load_strobe", load, 1);
    endtask

    // Wait (bounded) for done; returns at the negedge of the done cycle.
    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < W + 20);
        check("done_seen", done, 1);
        check("done_latency", cyc - load_cyc, W + 1);
        done_cyc = cyc;
    endtask

    task automatic expect_no_loads(input int ncyc);
        int seen;
        seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (load === 1'b1) seen++;
        end
        check("no_extra_load", seen, 0);
    endtask

    initial begin
        logic [63:0] r1, r2;
        rst   = 1'b1;
        start = 1'b0;
        a_val = '0;
        b_val = '0;
        repeat (3) @(negedge clk);
        check("rst_load", load, 0);
        check("rst_shift", shift, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cout", cout, 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;

        // Directed sums
        issue(32'd5, 32'd7);               wait_done();
        issue(32'hFFFF_FFFF, 32'h0000_0001); wait_done();
        issue(32'h7FFF_FFFF, 32'h0000_0001); wait_done();

        // Start pulses mid-operation and during DONE are ignored
        issue(32'h0F0F_0F0F, 32'h1234_5678);
        for (int k = 2; k <= 21; k++) begin
            @(negedge clk);
            start = (k == 5 || k == 20);
        end
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        expect_no_loads(4);

        // Start held high: one operation plus one re-accept after done
        @(negedge clk);
        a_val = 32'hDEAD_BEEF;
        b_val = 32'h0BAD_F00D;
        start = 1'b1;
        exp_q.push_back(model(a_val, b_val));
        exp_q.push_back(model(a_val, b_val));
        @(posedge clk);
        @(negedge clk);
        load_cyc = cyc;
        check("held_load", load, 1);
        wait_done();
        @(negedge clk);
        @(negedge clk);
        check("held_reaccept_load", load, 1);
        check("held_reaccept_gap", cyc - done_cyc, 2);
        start    = 1'b0;
        load_cyc = cyc;
        wait_done();
        expect_no_loads(5);

        // Reset in the 10th SHIFT cycle, then a clean run
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int k = 2; k <= 11; k++) @(negedge clk);
        check("shift_before_rst", shift, 1);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_shift", shift, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_cout", cout, 0);
        check("post_rst_done", done, 0);
        rst = 1'b0;
        void'(exp_q.pop_back());
        issue(32'h1234_5678, 32'h1111_1111); wait_done();

        // Back-to-back: load exactly two cycles after the previous done
        issue(32'h8000_0000, 32'h8000_0000);
        check("b2b_gap", load_cyc - done_cyc, 2);
        wait_done();

        // Randomized operands with random idle gaps
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            r1 = {$urandom(), $urandom()};
            r2 = {$urandom(), $urandom()};
            issue(r1[W-1:0], r2[W-1:0]);
            wait_done();
        end

        expect_no_loads(3);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if the run wedges
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
